jump_unit_ras: RTL and testbench
================================

// Module: jump_unit_ras
// PURPOSE
//  Parametrised jump/branch-target unit for J-format and JR-format control flow. Computes link (PC+2) and
//  target (PC+2+imm for J/JAL, Rs+imm for JR/JALR), flags signed overflow, and registers results behind a
//  valid/ready handshake. Maintains a return-address stack (RAS) so decode can predict JR returns.
//  Sits between decode and the PC-select mux; one result per accepted instruction, 1-cycle latency.
// PARAMETERS
//  WIDTH   16  datapath width of PC, imm, Rs and all address outputs (>=4)
//  DEPTH   8   RAS entries (power of 2, >=2)
// PORTS
//  clk       in   1      clock; all state updates on rising edge
//  rst       in   1      synchronous, active-high reset
//  flush     in   1      pipeline flush: clears RAS and output register
//  in_valid  in   1      instruction fields valid
//  in_ready  out  1      unit can accept this cycle
//  instr     in   5      opcode: 00100 J, 00101 JR, 00110 JAL, 00111 JALR; else illegal
//  cur_pc    in   WIDTH  PC of the instruction
//  imm       in   WIDTH  sign-extended displacement
//  rs_val    in   WIDTH  Rs operand (used by JR/JALR)
//  out_valid out  1      registered result valid
//  out_ready in   1      consumer takes result
//  nxt_pc    out  WIDTH  computed target
//  new_r7    out  WIDTH  link value PC+2
//  link_we   out  1      1 for JAL/JALR (write new_r7 to R7)
//  pred_pc   out  WIDTH  RAS top captured at accept (JR only, else 0)
//  pred_hit  out  1      JR and RAS non-empty and pred_pc==nxt_pc
//  err       out  1      signed overflow in either add, or illegal opcode
//  ras_empty out  1      RAS count==0 (combinational from state)
//  ras_full  out  1      RAS count==DEPTH
// BEHAVIOUR
//  - Reset / flush: out_valid=0, all data outputs 0, RAS count=0, ptr=0; ras_empty=1, ras_full=0.
//  - in_ready = ~out_valid | out_ready, forced 0 during rst or flush. Accept = in_valid & in_ready.
//  - On accept, next cycle: out_valid=1 and all outputs hold that instruction's result until popped.
//    No accept & out_ready: out_valid falls to 0, data outputs hold. Back-to-back throughput 1/cycle.
//  - Arithmetic, WIDTH bits, wrap mod 2^WIDTH: link=cur_pc+2; base=(JR|JALR)?rs_val:link; nxt_pc=base+imm.
//  - Overflow: of1 = ~cur_pc[MSB] & link[MSB]; of2 = base[MSB]==imm[MSB] & nxt_pc[MSB]!=base[MSB].
//    err = of1|of2|illegal. Result still produced (wrapped) when err=1.
//  - Illegal opcode: nxt_pc=link, link_we=0, pred_hit=0, err=1, RAS untouched.
//  - RAS (circular, ptr=next free slot): JAL/JALR accept pushes link; count saturates at DEPTH.
//    Push when full overwrites oldest entry (ptr wraps), ras_full stays 1.
//  - JR accept pops: pred_pc=stack[ptr-1], count-1. JR on empty: no pop, pred_pc=0, pred_hit=0, no error.
//  - JALR pops then pushes in the same accept (net count unchanged, top replaced by new link).
//  - J: no RAS change. pred_pc/pred_hit sampled from pre-update stack at accept.
//  - flush has priority over accept; rst has priority over flush. Mid-transfer reset discards result.
// TESTING
//  1. rst=1 one cycle -> out_valid=0, nxt_pc=0, ras_empty=1, in_ready=0 during rst, 1 after.
//  2. JAL pc=0x0100 imm=0x0010 -> next cycle nxt_pc=0x0112, new_r7=0x0102, link_we=1, err=0;
//     then JR rs_val=0x0102 imm=0 -> pred_pc=0x0102, pred_hit=1, ras_empty=1.
//  3. J pc=0x7FFE imm=0 -> new_r7=0x8000, err=1 (of1); J pc=0x0000 imm=0x8000 -> nxt_pc=0x8002, err=0.
//  4. DEPTH=8: 9 JALs pc=0x0000,0x0010,..,0x0080 -> ras_full=1; 8 JRs pop 0x0082..0x0012, 9th JR pred_hit=0.
//  5. Hold out_ready=0 with in_valid=1 -> in_ready=0, outputs stable 5 cycles; release -> next accepted.
//  6. flush with in_valid=1 and 3 entries -> no accept, out_valid=0, ras_empty=1; instr=5'b11111 -> err=1.

Source files
------------

// File: rtl/jump_unit_ras.sv
// Jump/branch-target unit: computes link and target for J/JR/JAL/JALR, flags overflow,
// registers results behind valid/ready, and keeps a circular return-address stack.
module jump_unit_ras #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       instr,
    input  logic [WIDTH-1:0] cur_pc,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] rs_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] nxt_pc,
    output logic [WIDTH-1:0] new_r7,
    output logic             link_we,
    output logic [WIDTH-1:0] pred_pc,
    output logic             pred_hit,
    output logic             err,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEPTH + 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [4:0] {
        OP_J    = 5'b00100,
        OP_JR   = 5'b00101,
        OP_JAL  = 5'b00110,
        OP_JALR = 5'b00111
    } op_e;

    logic [WIDTH-1:0] r_stack [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic             w_is_j, w_is_jr, w_is_jal, w_is_jalr, w_legal;
    logic             w_nonempty;
    logic [PW-1:0]    w_top_idx;
    logic [WIDTH-1:0] w_top, w_link, w_base, w_sum, w_target, w_pred_pc;
    logic             w_of1, w_of2, w_err, w_pred_hit;

    always_comb begin
        in_ready   = (~out_valid | out_ready) & ~rst & ~flush;
        w_accept   = in_valid & in_ready;

        w_is_j     = (instr == OP_J);
        w_is_jr    = (instr == OP_JR);
        w_is_jal   = (instr == OP_JAL);
        w_is_jalr  = (instr == OP_JALR);
        w_legal    = w_is_j | w_is_jr | w_is_jal | w_is_jalr;

        w_link     = cur_pc + WIDTH'(2);
        w_base     = (w_is_jr | w_is_jalr) ? rs_val : w_link;
        w_sum      = w_base + imm;
        w_of1      = ~cur_pc[MSB] & w_link[MSB];
        w_of2      = (w_base[MSB] == imm[MSB]) & (w_sum[MSB] != w_base[MSB]);
        w_target   = w_legal ? w_sum : w_link;
        w_err      = ~w_legal | w_of1 | w_of2;

        // ptr points at the next free slot, so the top lives one below (wrapping)
        w_nonempty = (r_count != '0);
        w_top_idx  = r_ptr - PW'(1);
        w_top      = r_stack[w_top_idx];
        w_pred_pc  = (w_is_jr & w_nonempty) ? w_top : '0;
        w_pred_hit = w_is_jr & w_nonempty & (w_top == w_sum);

        ras_empty  = (r_count == '0);
        ras_full   = (r_count == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_valid <= 1'b0;
            nxt_pc    <= '0;
            new_r7    <= '0;
            link_we   <= 1'b0;
            pred_pc   <= '0;
            pred_hit  <= 1'b0;
            err       <= 1'b0;
            r_ptr     <= '0;
            r_count   <= '0;
        end else begin
            if (w_accept) begin
                out_valid <= 1'b1;
                nxt_pc    <= w_target;
                new_r7    <= w_link;
                link_we   <= w_is_jal | w_is_jalr;
                pred_pc   <= w_pred_pc;
                pred_hit  <= w_pred_hit;
                err       <= w_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (w_accept) begin
                if (w_is_jal) begin
                    // when full, the slot at ptr holds the oldest entry and is overwritten
                    r_stack[r_ptr] <= w_link;
                    r_ptr          <= r_ptr + PW'(1);
                    if (!ras_full)
                        r_count <= r_count + CW'(1);
                end else if (w_is_jr) begin
                    if (w_nonempty) begin
                        r_ptr   <= w_top_idx;
                        r_count <= r_count - CW'(1);
                    end
                end else if (w_is_jalr) begin
                    // pop-then-push collapses to replacing the top in place
                    if (w_nonempty) begin
                        r_stack[w_top_idx] <= w_link;
                    end else begin
                        r_stack[r_ptr] <= w_link;
                        r_ptr          <= r_ptr + PW'(1);
                        r_count        <= CW'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_jump_unit_ras.sv
// Directed bench for jump_unit_ras: a behavioural RAS/arithmetic model feeds a scoreboard
// that is compared against the registered outputs every cycle.
module tb_jump_unit_ras;

    localparam int W = 16;
    localparam int D = 8;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic [4:0]   instr;
    logic [W-1:0] cur_pc, imm, rs_val;
    logic         in_ready, out_valid, link_we, pred_hit, err, ras_empty, ras_full;
    logic [W-1:0] nxt_pc, new_r7, pred_pc;

    jump_unit_ras #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .cur_pc(cur_pc), .imm(imm), .rs_val(rs_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .nxt_pc(nxt_pc), .new_r7(new_r7), .link_we(link_we),
        .pred_pc(pred_pc), .pred_hit(pred_hit), .err(err),
        .ras_empty(ras_empty), .ras_full(ras_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] nxt, r7, pred;
        logic         lwe, hit, er;
    } res_t;

    res_t         sb[$];
    logic [W-1:0] ras[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept();
        res_t r;
        logic [W-1:0] link, base, sum;
        logic jr, jalr, jal, legal, of1, of2;
        jr    = (instr == 5'b00101);
        jalr  = (instr == 5'b00111);
        jal   = (instr == 5'b00110);
        legal = jr | jalr | jal | (instr == 5'b00100);
        link  = cur_pc + 16'd2;
        base  = (jr | jalr) ? rs_val : link;
        sum   = base + imm;
        of1   = !cur_pc[W-1] && link[W-1];
        of2   = (base[W-1] == imm[W-1]) && (sum[W-1] != base[W-1]);
        r.r7  = link;
        r.nxt = legal ? sum : link;
        r.lwe = jal | jalr;
        r.er  = !legal || of1 || of2;
        r.pred = '0;
        r.hit  = 1'b0;
        if (jr && ras.size() > 0) begin
            r.pred = ras[$];
            r.hit  = (ras[$] == sum);
            void'(ras.pop_back());
        end
        if (jalr) begin
            if (ras.size() > 0) void'(ras.pop_back());
            ras.push_back(link);
        end
        if (jal) begin
            ras.push_back(link);
            if (ras.size() > D) void'(ras.pop_front());
        end
        sb.push_back(r);
    endtask

    // Called just after a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic exp_ir, acc, take;
        #1;
        exp_ir = !rst && !flush && (sb.size() == 0 || out_ready);
        check("in_ready", in_ready, exp_ir);
        acc  = in_valid && exp_ir;
        take = (sb.size() > 0) && out_ready;
        @(posedge clk);
        #1;
        if (rst || flush) begin
            sb.delete();
            ras.delete();
        end else begin
            if (take) void'(sb.pop_front());
            if (acc) model_accept();
        end
        check("out_valid", out_valid, sb.size() > 0);
        check("ras_empty", ras_empty, ras.size() == 0);
        check("ras_full", ras_full, ras.size() == D);
        if (sb.size() > 0) begin
            check("nxt_pc", nxt_pc, sb[0].nxt);
            check("new_r7", new_r7, sb[0].r7);
            check("link_we", link_we, sb[0].lwe);
            check("pred_pc", pred_pc, sb[0].pred);
            check("pred_hit", pred_hit, sb[0].hit);
            check("err", err, sb[0].er);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [4:0] op, input logic [W-1:0] pc,
                         input logic [W-1:0] im, input logic [W-1:0] rs);
        in_valid = 1'b1;
        instr    = op;
        cur_pc   = pc;
        imm      = im;
        rs_val   = rs;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        instr    = 5'b00000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = '0; cur_pc = '0; imm = '0; rs_val = '0;
        @(negedge clk);

        // 1. reset
        drive(5'b00110, 16'h0040, 16'h0000, 16'h0000);
        step();
        check("rst_nxt_pc", nxt_pc, 16'h0000);
        check("rst_new_r7", new_r7, 16'h0000);
        rst = 1'b0;
        idle();
        step();

        // 2. JAL then matching JR
        drive(5'b00110, 16'h0100, 16'h0010, 16'h0000);
        step();
        check("t2_nxt", nxt_pc, 16'h0112);
        check("t2_r7", new_r7, 16'h0102);
        drive(5'b00101, 16'h0200, 16'h0000, 16'h0102);
        step();
        check("t2_pred", pred_pc, 16'h0102);
        check("t2_hit", pred_hit, 1'b1);
        idle();
        step();

        // 3. overflow cases
        drive(5'b00100, 16'h7FFE, 16'h0000, 16'h0000);
        step();
        check("t3_of1_err", err, 1'b1);
        drive(5'b00100, 16'h0000, 16'h8000, 16'h0000);
        step();
        check("t3_nxt", nxt_pc, 16'h8002);
        drive(5'b00111, 16'h1000, 16'h7000, 16'h7000);
        step();
        drive(5'b00101, 16'h0300, 16'h0004, 16'h0FFE);
        step();

        // 4. fill past depth, then drain
        for (int i = 0; i < 9; i++) begin
            drive(5'b00110, 16'(i * 16), 16'h0004, 16'h0000);
            step();
        end
        check("t4_full", ras_full, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(5'b00101, 16'h0500, 16'h0000, 16'(16'h0082 - 16'(i * 16)));
            step();
        end
        drive(5'b00101, 16'h0500, 16'h0000, 16'h0002);
        step();
        check("t4_empty_hit", pred_hit, 1'b0);
        check("t4_empty_pred", pred_pc, 16'h0000);

        // 5. backpressure
        drive(5'b00100, 16'h0A00, 16'h0020, 16'h0000);
        step();
        out_ready = 1'b0;
        drive(5'b00110, 16'h0B00, 16'hFFF0, 16'h0000);
        for (int i = 0; i < 5; i++) step();
        out_ready = 1'b1;
        step();
        check("t5_next_nxt", nxt_pc, 16'h0AF2);
        idle();
        step();

        // 6. flush with entries present, then illegal opcode
        for (int i = 0; i < 3; i++) begin
            drive(5'b00110, 16'(16'h0C00 + 16'(i * 4)), 16'h0000, 16'h0000);
            step();
        end
        flush = 1'b1;
        drive(5'b00110, 16'h0D00, 16'h0000, 16'h0000);
        step();
        flush = 1'b0;
        drive(5'b00101, 16'h0E00, 16'h0000, 16'h0C0A);
        step();
        drive(5'b11111, 16'h0F00, 16'h0100, 16'h0000);
        step();
        check("t6_illegal_err", err, 1'b1);
        check("t6_illegal_nxt", nxt_pc, 16'h0F02);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
